// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) with
// valid/ready handshakes on both sides and a significant-digit count.

module bcd_dabble_digit (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int NDW    = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      binary_input,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [NDW-1:0]        num_digits
);

  // Decimal digits needed for the largest WIDTH-bit value, 2^WIDTH - 1.
  function automatic int min_digits(input int w);
    longint unsigned v;
    int              n;
    v = (64'd1 << w) - 64'd1;
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n = n + 1;
    end
    return n;
  endfunction

  generate
    if (WIDTH < 4 || WIDTH > 32 || DIGITS < min_digits(WIDTH)) begin : g_bad_cfg
      $error("bin_to_bcd_seq: illegal WIDTH/DIGITS combination");
    end
  endgenerate

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  typedef struct packed {
    logic [4*DIGITS-1:0] bcd;
    logic [NDW-1:0]      nd;
  } res_t;

  state_t                  state, state_nxt;
  logic [WIDTH-1:0]        sr;
  logic [CW-1:0]           cnt;
  logic [DIGITS-1:0][3:0]  acc, adj;
  logic [4*DIGITS-1:0]     adj_flat, acc_nxt;
  logic [NDW-1:0]          nd_nxt;
  res_t                    res_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_dabble_digit u_dig (.d(acc[g]), .q(adj[g]));
  end

  // Adjusted digits shifted up by one, MSB of the binary register entering at the bottom.
  assign adj_flat = adj;
  assign acc_nxt  = (adj_flat << 1) | {{(4*DIGITS-1){1'b0}}, sr[WIDTH-1]};

  always_comb begin
    nd_nxt = NDW'(1);
    for (int k = 1; k < DIGITS; k++)
      if (acc_nxt[4*k +: 4] != 4'd0) nd_nxt = NDW'(k + 1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)          state_nxt = S_SHIFT;
      S_SHIFT: if (cnt == CW'(1))     state_nxt = S_DONE;
      S_DONE:  if (out_ready)         state_nxt = S_IDLE;
      default:                        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      sr    <= '0;
      acc   <= '0;
      cnt   <= '0;
      res_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (in_valid) begin
          sr  <= binary_input;
          acc <= '0;
          cnt <= CW'(WIDTH);
        end
        S_SHIFT: begin
          acc <= acc_nxt;
          sr  <= sr << 1;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            res_q.bcd <= acc_nxt;
            res_q.nd  <= nd_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state == S_IDLE);
  assign out_valid  = (state == S_DONE);
  assign bcd_out    = res_q.bcd;
  assign num_digits = res_q.nd;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench: default 16-bit/5-digit converter plus a 4-bit/2-digit instance
// checked against the legacy tens/ones mapping.

module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        d_vld = 1'b0, d_rdy, d_ov, d_ordy = 1'b1;
  logic [15:0] d_din = '0;
  logic [19:0] d_bcd;
  logic [2:0]  d_nd;

  logic        s_vld = 1'b0, s_rdy, s_ov, s_ordy = 1'b1;
  logic [3:0]  s_din = '0;
  logic [7:0]  s_bcd;
  logic [1:0]  s_nd;

  bin_to_bcd_seq u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(d_vld), .in_ready(d_rdy),
    .binary_input(d_din), .out_valid(d_ov), .out_ready(d_ordy),
    .bcd_out(d_bcd), .num_digits(d_nd));

  bin_to_bcd_seq #(.WIDTH(4), .DIGITS(2)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(s_vld), .in_ready(s_rdy),
    .binary_input(s_din), .out_valid(s_ov), .out_ready(s_ordy),
    .bcd_out(s_bcd), .num_digits(s_nd));

  typedef struct {
    logic        sel;   // 1 = 4-bit instance
    logic [15:0] din;
    logic [19:0] bcd;
    logic [2:0]  nd;
  } vec_t;

  vec_t tv[$];
  int   n_vec = 0, n_err = 0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input logic sel); return sel ? s_rdy : d_rdy; endfunction
  function automatic logic ov(input logic sel);  return sel ? s_ov  : d_ov;  endfunction
  function automatic logic [19:0] bcd(input logic sel); return sel ? {12'd0, s_bcd} : d_bcd; endfunction
  function automatic logic [2:0] nd(input logic sel);   return sel ? {1'b0, s_nd} : d_nd;   endfunction

  // Full convert-and-consume with out_ready high; starts and ends just after a rising edge.
  task automatic run(input vec_t v);
    int n;
    n_vec++;
    n = 0;
    while (!rdy(v.sel) && n < 100) begin @(posedge clk); #1; n++; end
    chk("in_ready_before", {31'd0, rdy(v.sel)}, 1);
    if (v.sel) begin s_din = v.din[3:0]; s_vld = 1'b1; end
    else       begin d_din = v.din;      d_vld = 1'b1; end
    @(posedge clk); #1;
    s_vld = 1'b0; d_vld = 1'b0;
    n = 0;
    while (!ov(v.sel) && n < 100) begin @(posedge clk); #1; n++; end
    chk($sformatf("latency[%0d]", v.din), n, v.sel ? 4 : 16);
    chk($sformatf("bcd[%0d]", v.din), {12'd0, bcd(v.sel)}, {12'd0, v.bcd});
    chk($sformatf("nd[%0d]", v.din), {29'd0, nd(v.sel)}, {29'd0, v.nd});
    @(posedge clk); #1;
    chk("out_valid_after_hs", {31'd0, ov(v.sel)}, 0);
    chk("in_ready_after_hs", {31'd0, rdy(v.sel)}, 1);
  endtask

  int        bb_val[4] = '{9, 10, 99, 100};
  logic [19:0] bb_bcd[4] = '{20'h00009, 20'h00010, 20'h00099, 20'h00100};
  int        bb_nd[4]  = '{1, 2, 2, 3};

  initial begin
    int n, acc_cyc, prev_cyc, hits;

    tv.push_back('{1'b0, 16'd0,     20'h00000, 3'd1});
    tv.push_back('{1'b0, 16'd65535, 20'h65535, 3'd5});
    tv.push_back('{1'b0, 16'd1234,  20'h01234, 3'd4});
    tv.push_back('{1'b0, 16'd255,   20'h00255, 3'd3});
    tv.push_back('{1'b0, 16'd10000, 20'h10000, 3'd5});
    tv.push_back('{1'b0, 16'd9999,  20'h09999, 3'd4});
    tv.push_back('{1'b0, 16'd50505, 20'h50505, 3'd5});
    for (int i = 0; i < 16; i++)
      tv.push_back('{1'b1, 16'(i),
                     (i > 9) ? {12'd0, 4'd1, 4'(i - 10)} : {12'd0, 4'd0, 4'(i)},
                     (i > 9) ? 3'd2 : 3'd1});

    // Reset state
    #3;
    n_vec++;
    chk("rst_in_ready", {31'd0, d_rdy}, 1);
    chk("rst_out_valid", {31'd0, d_ov}, 0);
    chk("rst_bcd", {12'd0, d_bcd}, 0);
    chk("rst_nd", {29'd0, d_nd}, 0);
    chk("rst_small_bcd", {24'd0, s_bcd}, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tv[i]) run(tv[i]);

    // Backpressure: result held for 10 cycles, new in_valid ignored
    n_vec++;
    d_ordy = 1'b0; d_din = 16'd1234; d_vld = 1'b1;
    @(posedge clk); #1;
    d_din = 16'd777;
    n = 0;
    while (!d_ov && n < 100) begin @(posedge clk); #1; n++; end
    chk("bp_latency", n, 16);
    for (int k = 0; k < 10; k++) begin
      chk("bp_out_valid", {31'd0, d_ov}, 1);
      chk("bp_in_ready", {31'd0, d_rdy}, 0);
      chk("bp_bcd", {12'd0, d_bcd}, 32'h01234);
      chk("bp_nd", {29'd0, d_nd}, 4);
      @(posedge clk); #1;
    end
    d_vld = 1'b0; d_ordy = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after", {31'd0, d_rdy}, 1);
    chk("bp_out_valid_after", {31'd0, d_ov}, 0);
    @(posedge clk); #1;
    chk("bp_bcd_held_idle", {12'd0, d_bcd}, 32'h01234);
    chk("bp_nd_held_idle", {29'd0, d_nd}, 4);

    // Back-to-back with in_valid held high
    prev_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      d_din = bb_val[i][15:0]; d_vld = 1'b1;
      n = 0;
      while (!d_rdy && n < 100) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      acc_cyc = cyc;
      if (i > 0) chk("b2b_interval", acc_cyc - prev_cyc, 18);
      prev_cyc = acc_cyc;
      d_din = 16'hFFFF;
      n = 0;
      while (!d_ov && n < 100) begin @(posedge clk); #1; n++; end
      chk("b2b_latency", n, 16);
      chk($sformatf("b2b_bcd[%0d]", bb_val[i]), {12'd0, d_bcd}, {12'd0, bb_bcd[i]});
      chk($sformatf("b2b_nd[%0d]", bb_val[i]), {29'd0, d_nd}, bb_nd[i]);
    end
    d_vld = 1'b0;
    @(posedge clk); #1;

    // Reset seven cycles into a conversion
    n_vec++;
    d_din = 16'd4321; d_vld = 1'b1;
    @(posedge clk); #1;
    d_vld = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, d_ov}, 0);
    chk("mid_rst_bcd", {12'd0, d_bcd}, 0);
    chk("mid_rst_nd", {29'd0, d_nd}, 0);
    chk("mid_rst_in_ready", {31'd0, d_rdy}, 1);
    @(posedge clk); #1; rst_n = 1'b1;
    hits = 0;
    repeat (30) begin @(posedge clk); #1; if (d_ov) hits++; end
    chk("post_rst_no_result", hits, 0);
    run('{1'b0, 16'd4321, 20'h04321, 3'd4});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

endmodule
